// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, ALU ops,
// controller states and fault codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_HALT
  } state_e;

  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR) || (f == FN_SLT);
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] f);
    alu_op_e op;
    op = ALU_ADD;
    case (f)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_if.sv
// Unified instruction/data memory port: one request at a time, completed by mem_ready.
interface mips_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wd,
    input  mem_rd, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wd,
    output mem_rd, mem_ready
  );
endinterface

// File: rtl/mc_control.sv
// Sequencing FSM for the multicycle core, including the memory wait timeout.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | request instruction at pc, wait for ready
// DECODE   | read rs/rt, precompute branch target, dispatch
// MEMADR   | effective address for lw/sw
// MEMRD    | data read request, wait for ready
// MEMWB    | rf[rt] <= MDR
// MEMWR    | data write request, wait for ready
// EXEC     | R-type ALU operation
// ALUWB    | rf[rd] <= ALUOut
// BRANCH   | pc <= ALUOut when A == B
// ADDIEX   | A + signext(imm)
// ADDIWB   | rf[rt] <= ALUOut
// JUMP     | pc <= {pc[31:28], target, 2'b00}
// HALT     | terminal until reset (illegal op or timeout)
module mc_control
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output state_e     state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       retire,
  output logic       halted,
  output logic [1:0] fault
);

  localparam logic [31:0] WAIT_LOAD = (MAX_WAIT > 0) ? 32'(MAX_WAIT - 1) : 32'd0;

  logic [31:0] wait_cnt;
  logic        mem_state;
  logic        waiting;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign waiting   = mem_state && !mem_ready;

  // Reset gates the request so the bus goes quiet the instant reset rises.
  assign mem_req = mem_state && !reset;
  assign mem_we  = (state == S_MEMWR) && !reset;
  assign halted  = (state == S_HALT);
  assign retire  = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
                   (state == S_BRANCH) || (state == S_JUMP) ||
                   ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      fault    <= FAULT_NONE;
      wait_cnt <= WAIT_LOAD;
    end else if ((MAX_WAIT > 0) && waiting && (wait_cnt == 32'd0)) begin
      state <= S_HALT;
      fault <= FAULT_TIMEOUT;
    end else begin
      if (waiting) wait_cnt <= wait_cnt - 32'd1;
      else         wait_cnt <= WAIT_LOAD;
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            OP_RTYPE: begin
              if (funct_valid(funct)) begin
                state <= S_EXEC;
              end else begin
                state <= S_HALT;
                fault <= FAULT_ILLEGAL;
              end
            end
            default: begin
              state <= S_HALT;
              fault <= FAULT_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: datapath, register file and ALU around the
// mc_control sequencer, on a single shared memory port.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          MAX_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  mips_if.master      bus,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  fault
);

  state_e      state;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] aluout;
  logic [31:0] mdr;
  logic [31:0] rf [32];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_se;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] addr_full;
  logic        mem_req_w;
  logic        mem_we_w;
  logic [4:0]  unused_shamt;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign unused_shamt = ir[10:6];
  assign funct        = ir[5:0];
  assign imm_se       = {{16{ir[15]}}, ir[15:0]};
  assign rs_val       = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val       = (rt == 5'd0) ? 32'd0 : rf[rt];

  mc_control #(.MAX_WAIT(MAX_WAIT)) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .mem_ready (bus.mem_ready),
    .state     (state),
    .mem_req   (mem_req_w),
    .mem_we    (mem_we_w),
    .retire    (retire),
    .halted    (halted),
    .fault     (fault)
  );

  // Address and store data come straight from registers that do not move
  // while a request waits, so the bus stays stable across stalls.
  always_comb begin
    addr_full = pc;
    if ((state == S_MEMRD) || (state == S_MEMWR)) addr_full = aluout;
  end

  assign bus.mem_req  = mem_req_w;
  assign bus.mem_we   = mem_we_w;
  assign bus.mem_addr = addr_full[ADDR_W-1:0];
  assign bus.mem_wd   = b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir <= bus.mem_rd;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a      <= rs_val;
          b      <= rt_val;
          aluout <= pc + (imm_se << 2);
        end
        S_MEMADR, S_ADDIEX: aluout <= a + imm_se;
        S_MEMRD:  if (bus.mem_ready) mdr <= bus.mem_rd;
        S_MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
        S_EXEC:   aluout <= alu_calc(funct_to_alu(funct), a, b);
        S_ALUWB:  if (rd != 5'd0) rf[rd] <= aluout;
        S_ADDIWB: if (rt != 5'd0) rf[rt] <= aluout;
        S_BRANCH: if (a == b) pc <= aluout;
        S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: per-instruction vector table plus
// hand-written sequences for stalls, loops, halt, timeout and mid-access reset.
module tb_mips_multicycle
  import mips_pkg::*;
;

  localparam logic [31:0] ILL  = 32'hFC00_0000;
  localparam logic [31:0] SENT = 32'hBAD0_BAD0;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        retire;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] pc2;
  logic        retire2;
  logic        halted2;
  logic [1:0]  fault2;

  mips_if #(.ADDR_W(32)) bus ();
  mips_if #(.ADDR_W(32)) bus2 ();

  mips_multicycle #(.RESET_PC(32'h0), .ADDR_W(32), .MAX_WAIT(0)) dut (
    .clock(clock), .reset(reset), .bus(bus), .pc(pc),
    .retire(retire), .halted(halted), .fault(fault)
  );

  mips_multicycle #(.RESET_PC(32'h0), .ADDR_W(32), .MAX_WAIT(4)) dut_to (
    .clock(clock), .reset(reset), .bus(bus2), .pc(pc2),
    .retire(retire2), .halted(halted2), .fault(fault2)
  );

  assign bus2.mem_ready = 1'b0;
  assign bus2.mem_rd    = 32'h0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // memory model: program/preload in mem, stores captured in wr_data
  logic [31:0] mem     [256];
  logic [31:0] wr_data [256];
  logic [7:0]  idx;
  logic [31:0] stall_addr;
  int          stall_n;
  int          pend;
  int          pend_nx;

  always_comb begin
    idx           = bus.mem_addr[9:2];
    bus.mem_rd    = mem[idx];
    bus.mem_ready = bus.mem_req && !((bus.mem_addr == stall_addr) && (pend < stall_n));
  end

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) wr_data[i] = SENT;
      pend_nx = 0;
    end else if (bus.mem_req && bus.mem_ready) begin
      if (bus.mem_we) wr_data[idx] = bus.mem_wd;
      pend_nx = 0;
    end else if (bus.mem_req) begin
      pend_nx = pend + 1;
    end else begin
      pend_nx = 0;
    end
  end

  always @(posedge clock) pend <= pend_nx;

  int cyc;
  int ret_n;
  int ret_t [16];

  always @(negedge clock) begin
    if (reset) begin
      cyc   = 0;
      ret_n = 0;
    end else begin
      cyc++;
      if (retire && (ret_n < 16)) begin
        ret_t[ret_n] = cyc;
        ret_n++;
      end
    end
  end

  int n_chk;
  int n_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                       input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0];
    t = rt[4:0];
    d = rd[4:0];
    return {OP_RTYPE, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                       input int imm);
    logic [4:0]  s, t;
    logic [15:0] im;
    s  = rs[4:0];
    t  = rt[4:0];
    im = imm[15:0];
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
    logic [25:0] tg;
    tg = tgt[25:0];
    return {op, tg};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic run_to_halt(input string nm, input int budget);
    int n;
    n = 0;
    while (!halted && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    #1;
    check({nm, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          va;
    int          vb;
    int          st_reg;
    logic [31:0] exp_addr;
    logic [31:0] exp;
    int          exp_cyc;
    int          exp_ret;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [31:0] ins, input int va, input int vb,
                         input int st_reg, input logic [31:0] exp_addr, input logic [31:0] exp,
                         input int exp_cyc, input int exp_ret);
    vec_t v;
    v.name = nm; v.ins = ins; v.va = va; v.vb = vb; v.st_reg = st_reg;
    v.exp_addr = exp_addr; v.exp = exp; v.exp_cyc = exp_cyc; v.exp_ret = exp_ret;
    vecs.push_back(v);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    reset      = 1'b1;
    stall_addr = 32'hFFFF_FFFF;
    stall_n    = 0;
    clear_mem();

    // slot0 addi r1,va  slot1 addi r2,vb  slot2 test  slot3 addi r4,0x55
    // slot4 sw st_reg,0x80(r0)  slot5 illegal
    add_vec("add",     enc_r(1, 2, 3, FN_ADD), 5, 7, 3, 32'h80, 32'd12, 4, 5);
    add_vec("sub",     enc_r(1, 2, 3, FN_SUB), 5, 7, 3, 32'h80, 32'hFFFF_FFFE, 4, 5);
    add_vec("and",     enc_r(1, 2, 3, FN_AND), 32'h0F0F, 32'h00FF, 3, 32'h80, 32'h0000_000F, 4, 5);
    add_vec("or",      enc_r(1, 2, 3, FN_OR), 32'h0F00, 32'h00F0, 3, 32'h80, 32'h0000_0FF0, 4, 5);
    add_vec("slt_neg", enc_r(1, 2, 3, FN_SLT), -3, 2, 3, 32'h80, 32'd1, 4, 5);
    add_vec("slt_pos", enc_r(1, 2, 3, FN_SLT), 2, -3, 3, 32'h80, 32'd0, 4, 5);
    add_vec("sub_wrap", enc_r(1, 2, 3, FN_SUB), -32768, 32767, 3, 32'h80, 32'hFFFF_0001, 4, 5);
    add_vec("addi",    enc_i(OP_ADDI, 1, 3, -10), 5, 0, 3, 32'h80, 32'hFFFF_FFFB, 4, 5);
    add_vec("r0_wr",   enc_r(1, 2, 0, FN_ADD), 5, 7, 0, 32'h80, 32'd0, 4, 5);
    add_vec("lw",      enc_i(OP_LW, 1, 3, 32'h44), 32'h40, 0, 3, 32'h80, 32'hDEAD_BEEF, 5, 5);
    add_vec("sw",      enc_i(OP_SW, 1, 2, 32'h40), 32'h4C, 32'h1234, 0, 32'h8C, 32'h0000_1234, 4, 5);
    add_vec("beq_t",   enc_i(OP_BEQ, 1, 2, 1), 6, 6, 4, 32'h80, 32'd0, 3, 4);
    add_vec("beq_nt",  enc_i(OP_BEQ, 1, 2, 1), 6, 7, 4, 32'h80, 32'h55, 3, 5);
    add_vec("j",       enc_j(OP_J, 4), 1, 2, 4, 32'h80, 32'd0, 3, 4);

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_fault", {30'd0, fault}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    // table vectors
    foreach (vecs[v]) begin
      reset = 1'b1;
      clear_mem();
      mem[0]  = enc_i(OP_ADDI, 0, 1, vecs[v].va);
      mem[1]  = enc_i(OP_ADDI, 0, 2, vecs[v].vb);
      mem[2]  = vecs[v].ins;
      mem[3]  = enc_i(OP_ADDI, 0, 4, 32'h55);
      mem[4]  = enc_i(OP_SW, 0, vecs[v].st_reg, 32'h80);
      mem[5]  = ILL;
      mem[33] = 32'hDEAD_BEEF;
      repeat (2) @(negedge clock);
      release_reset();
      run_to_halt(vecs[v].name, 60);
      check({vecs[v].name, "_data"}, wr_data[vecs[v].exp_addr[9:2]], vecs[v].exp);
      check({vecs[v].name, "_cycles"}, ret_t[2] - ret_t[1], vecs[v].exp_cyc);
      check({vecs[v].name, "_retires"}, ret_n, vecs[v].exp_ret);
      check({vecs[v].name, "_fault"}, {30'd0, fault}, 32'd1);
    end

    // four-instruction program, zero wait
    reset = 1'b1;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 5);
    mem[1] = enc_i(OP_ADDI, 0, 2, 7);
    mem[2] = enc_r(1, 2, 3, FN_ADD);
    mem[3] = enc_i(OP_SW, 0, 3, 0);
    mem[4] = ILL;
    repeat (2) @(negedge clock);
    release_reset();
    wait_cyc(16);
    check("prog_word0", wr_data[0], 32'd12);
    check("prog_retires", ret_n, 32'd4);
    check("prog_last_retire", ret_t[3], 32'd16);

    // lw with 3 stalled cycles
    reset = 1'b1;
    clear_mem();
    mem[0]  = enc_i(OP_LW, 0, 3, 32'h80);
    mem[1]  = enc_i(OP_SW, 0, 3, 32'h84);
    mem[2]  = ILL;
    mem[32] = 32'h1234_5678;
    stall_addr = 32'h80;
    stall_n    = 3;
    repeat (2) @(negedge clock);
    release_reset();
    for (int c = 1; c <= 8; c++) begin
      wait_cyc(1);
      if (c >= 4 && c <= 7) begin
        check($sformatf("lw_wait_req_c%0d", c), {31'd0, bus.mem_req}, 32'd1);
        check($sformatf("lw_wait_addr_c%0d", c), bus.mem_addr, 32'h80);
        check($sformatf("lw_wait_we_c%0d", c), {31'd0, bus.mem_we}, 32'd0);
      end
    end
    check("lw_stall_cycles", ret_t[0], 32'd8);
    run_to_halt("lw_stall", 40);
    check("lw_stall_data", wr_data[33], 32'h1234_5678);
    stall_addr = 32'hFFFF_FFFF;
    stall_n    = 0;

    // j to 0x10 then beq r0,r0,-1 loop
    reset = 1'b1;
    clear_mem();
    mem[0] = enc_j(OP_J, 4);
    mem[4] = enc_i(OP_BEQ, 0, 0, -1);
    repeat (2) @(negedge clock);
    release_reset();
    wait_cyc(13);
    check("loop_j_cycles", ret_t[0], 32'd3);
    for (int k = 1; k < 4; k++)
      check($sformatf("loop_beq_period_%0d", k), ret_t[k] - ret_t[k-1], 32'd3);
    check("loop_pc", pc, 32'h10);
    check("loop_fetch_addr", bus.mem_addr, 32'h10);

    // j 0x40 lands on an illegal opcode at 0x100
    reset = 1'b1;
    clear_mem();
    mem[0]  = enc_j(OP_J, 32'h40);
    mem[64] = ILL;
    repeat (2) @(negedge clock);
    release_reset();
    wait_cyc(4);
    check("j40_pc", pc, 32'h100);
    check("j40_addr", bus.mem_addr, 32'h100);
    run_to_halt("ill", 10);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ill_fault_%0d", k), {30'd0, fault}, 32'd1);
      check($sformatf("ill_req_%0d", k), {31'd0, bus.mem_req}, 32'd0);
      check($sformatf("ill_halted_%0d", k), {31'd0, halted}, 32'd1);
      wait_cyc(1);
    end

    // timeout instance: ready never comes
    reset = 1'b1;
    repeat (2) @(negedge clock);
    release_reset();
    for (int c = 1; c <= 4; c++) begin
      wait_cyc(1);
      check($sformatf("to_fault_c%0d", c), {30'd0, fault2}, 32'd0);
      check($sformatf("to_req_c%0d", c), {31'd0, bus2.mem_req}, 32'd1);
    end
    wait_cyc(1);
    check("to_fault_c5", {30'd0, fault2}, 32'd2);
    check("to_halted_c5", {31'd0, halted2}, 32'd1);
    check("to_req_c5", {31'd0, bus2.mem_req}, 32'd0);

    // reset while a store is stalled in MEMWR
    reset = 1'b1;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 3, 9);
    mem[1] = enc_i(OP_SW, 0, 3, 32'h80);
    mem[2] = ILL;
    stall_addr = 32'h80;
    stall_n    = 1000;
    repeat (2) @(negedge clock);
    release_reset();
    wait_cyc(9);
    check("mwr_req", {31'd0, bus.mem_req}, 32'd1);
    check("mwr_we", {31'd0, bus.mem_we}, 32'd1);
    check("mwr_wd", bus.mem_wd, 32'd9);
    reset = 1'b1;
    #1;
    check("mwr_rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("mwr_rst_pc", pc, 32'h0);
    clear_mem();
    mem[0] = enc_i(OP_SW, 0, 3, 32'h88);
    mem[1] = ILL;
    stall_n = 0;
    repeat (2) @(negedge clock);
    release_reset();
    wait_cyc(1);
    check("mwr_first_req", {31'd0, bus.mem_req}, 32'd1);
    check("mwr_first_addr", bus.mem_addr, 32'h0);
    run_to_halt("mwr", 20);
    check("mwr_r3_zero", wr_data[34], 32'd0);
    check("mwr_retires", ret_n, 32'd1);
    check("mwr_fault", {30'd0, fault}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
